// File: rtl/counting_element_if.sv
// counting_element_if: control/read-logic side bundle of one 8254 counting element.
// The master is the channel control/read logic; the slave is the counting element.
interface counting_element_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] initial_count;
    logic             cr_write;
    logic             load_new_count;
    logic             count_enable;
    logic [2:0]       mode;
    logic             bcd;
    logic             latch_cmd;
    logic             ol_release;
    logic [WIDTH-1:0] current_count;
    logic [WIDTH-1:0] ol_value;
    logic             ol_latched;
    logic             null_count;
    logic             tc_pulse;

    modport master (
        output initial_count, cr_write, load_new_count, count_enable, mode, bcd,
               latch_cmd, ol_release,
        input  current_count, ol_value, ol_latched, null_count, tc_pulse
    );

    modport slave (
        input  initial_count, cr_write, load_new_count, count_enable, mode, bcd,
               latch_cmd, ol_release,
        output current_count, ol_value, ol_latched, null_count, tc_pulse
    );
endinterface

// File: rtl/counting_element.sv
// counting_element: 8254 channel down-counter with binary/BCD step, mode 2/3 reload and output latch.
// Optional BCD arithmetic is built only when BCD_COUNT_EN is defined; otherwise bcd is ignored.
module counting_element #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_COUNT = '0
) (
    input logic                clk,
    input logic                rst_n,
    counting_element_if.slave  bus
);
    logic             mode2;
    logic             mode3;
    logic [1:0]       step;
    logic [WIDTH-1:0] ce;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] dec_val;
    logic [WIDTH-1:0] next_ce;
    logic             reload;
    logic             hit_zero;
    logic             ol_hold;
    logic [WIDTH-1:0] ol_value;
    logic             ol_latched;
    logic             null_count;
    logic             tc_pulse;

    // Modes 6/7 alias to 2/3, so only the low two mode bits matter.
    assign mode2    = bus.mode[1:0] == 2'b10;
    assign mode3    = bus.mode[1:0] == 2'b11;
    assign step     = mode3 ? 2'd2 : 2'd1;
    assign load_val = mode3 ? {bus.initial_count[WIDTH-1:1], 1'b0} : bus.initial_count;
    assign reload   = bus.count_enable & ((mode2 & ce == WIDTH'(1)) | (mode3 & ce == WIDTH'(2)));
    assign hit_zero = bus.count_enable & ~mode2 & ~mode3 & ce == WIDTH'(1);

`ifdef BCD_COUNT_EN
    localparam int DIGITS = WIDTH / 4;

    // Digit-serial borrow chain; non-BCD digits just wrap within 4 bits.
    function automatic logic [WIDTH-1:0] bcd_dec(input logic [WIDTH-1:0] v, input logic [1:0] s);
        logic [3:0] dig;
        logic [3:0] sub;
        logic       brw;
        bcd_dec = v;
        sub     = {2'b00, s};
        for (int i = 0; i < DIGITS; i++) begin
            dig = v[4*i +: 4];
            brw = dig < sub;
            bcd_dec[4*i +: 4] = brw ? dig + 4'd10 - sub : dig - sub;
            sub = {3'b000, brw};
        end
    endfunction

    assign dec_val = bus.bcd ? bcd_dec(ce, step) : ce - WIDTH'(step);
`else
    logic unused_bcd;
    assign unused_bcd = bus.bcd;
    assign dec_val    = ce - WIDTH'(step);
`endif

    assign next_ce = bus.load_new_count ? load_val :
                     reload             ? load_val :
                     bus.count_enable   ? dec_val  : ce;
    // A release this edge lets the latch track (and possibly re-latch) the new count.
    assign ol_hold = ol_latched & ~bus.ol_release;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce         <= RESET_COUNT;
            ol_value   <= RESET_COUNT;
            ol_latched <= 1'b0;
            null_count <= 1'b1;
            tc_pulse   <= 1'b0;
        end else begin
            ce         <= next_ce;
            tc_pulse   <= ~bus.load_new_count & (reload | hit_zero);
            null_count <= bus.cr_write ? 1'b1 : bus.load_new_count ? 1'b0 : null_count;
            ol_latched <= ol_hold | bus.latch_cmd;
            if (!ol_hold) ol_value <= next_ce;
        end
    end

    assign bus.current_count = ce;
    assign bus.ol_value      = ol_value;
    assign bus.ol_latched    = ol_latched;
    assign bus.null_count    = null_count;
    assign bus.tc_pulse      = tc_pulse;
endmodule

// File: tb/tb_counting_element.sv
// tb_counting_element: directed vectors with a queue scoreboard checked by an independent monitor.
module tb_counting_element;
    localparam int X = -1;
    localparam int T = -2;

    typedef struct {
        string       nm;
        logic [15:0] ce;
        logic        tc;
        int          olv;
        int          oll;
        int          nc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    exp_t q[$];

    counting_element_if #(.WIDTH(16)) bus();

    counting_element #(.WIDTH(16), .RESET_COUNT(16'h0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

`ifdef BCD_COUNT_EN
    localparam bit B = 1'b1;
`else
    localparam bit B = 1'b0;
`endif

    task automatic chk(input string nm, input string f, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=%h required=%h", nm, f, act, req);
        end
    endtask

    task automatic push(input string nm, input logic [15:0] ce, input logic tc,
                        input int olv, input int oll, input int nc);
        exp_t e;
        e.nm = nm; e.ce = ce; e.tc = tc; e.olv = olv; e.oll = oll; e.nc = nc;
        q.push_back(e);
    endtask

    task automatic cfg(input logic [2:0] md, input logic bc, input logic [15:0] ic);
        if (clk) @(negedge clk);
        bus.mode = md;
        bus.bcd = bc;
        bus.initial_count = ic;
    endtask

    task automatic cyc(input string nm, input bit ld, input bit en, input bit cw, input bit lc,
                       input bit rl, input logic [15:0] ce, input logic tc,
                       input int olv, input int oll, input int nc);
        if (clk) @(negedge clk);
        bus.load_new_count = ld;
        bus.count_enable = en;
        bus.cr_write = cw;
        bus.latch_cmd = lc;
        bus.ol_release = rl;
        push(nm, ce, tc, olv, oll, nc);
        @(posedge clk);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.nm, "current_count", bus.current_count, e.ce);
                chk(e.nm, "tc_pulse", {15'd0, bus.tc_pulse}, {15'd0, e.tc});
                if (e.olv == T) chk(e.nm, "ol_value", bus.ol_value, e.ce);
                else if (e.olv >= 0) chk(e.nm, "ol_value", bus.ol_value, 16'(e.olv));
                if (e.oll >= 0) chk(e.nm, "ol_latched", {15'd0, bus.ol_latched}, 16'(e.oll));
                if (e.nc >= 0) chk(e.nm, "null_count", {15'd0, bus.null_count}, 16'(e.nc));
            end
        end
    end

    initial begin
        bus.initial_count = '0; bus.cr_write = 0; bus.load_new_count = 0; bus.count_enable = 0;
        bus.mode = 3'd0; bus.bcd = 0; bus.latch_cmd = 0; bus.ol_release = 0;
        push("reset", 16'h0000, 1'b0, 0, 0, 1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        cfg(3'd0, 1'b0, 16'h0005);
        cyc("m0_load_en", 1, 1, 0, 0, 0, 16'h0005, 0, T, 0, 0);
        for (int v = 4; v >= 1; v--) cyc("m0_dec", 0, 1, 0, 0, 0, 16'(v), 0, T, 0, X);
        cyc("m0_tc", 0, 1, 0, 0, 0, 16'h0000, 1, T, 0, X);
        cyc("m0_wrap", 0, 1, 0, 0, 0, 16'hFFFF, 0, T, 0, X);
        cyc("m0_wrap2", 0, 1, 0, 0, 0, 16'hFFFE, 0, X, X, X);

        cfg(3'd0, 1'b1, 16'h0010);
        cyc("bcd_load", 1, 0, 0, 0, 0, 16'h0010, 0, T, 0, 0);
        cyc("bcd_dec", 0, 1, 0, 0, 0, B ? 16'h0009 : 16'h000F, 0, T, 0, X);
        cfg(3'd0, 1'b1, 16'h0000);
        cyc("bcd_load0", 1, 0, 0, 0, 0, 16'h0000, 0, T, 0, X);
        cyc("bcd_wrap", 0, 1, 0, 0, 0, B ? 16'h9999 : 16'hFFFF, 0, T, 0, X);
        cfg(3'd3, 1'b1, 16'h0000);
        cyc("bcd_m3_load", 1, 0, 0, 0, 0, 16'h0000, 0, T, 0, X);
        cyc("bcd_m3_wrap", 0, 1, 0, 0, 0, B ? 16'h9998 : 16'hFFFE, 0, T, 0, X);

        cfg(3'd3, 1'b0, 16'h0007);
        cyc("m3_load", 1, 0, 0, 0, 0, 16'h0006, 0, T, 0, 0);
        for (int r = 0; r < 2; r++) begin
            cyc("m3_dec4", 0, 1, 0, 0, 0, 16'h0004, 0, T, 0, X);
            cyc("m3_dec2", 0, 1, 0, 0, 0, 16'h0002, 0, T, 0, X);
            cyc("m3_reload", 0, 1, 0, 0, 0, 16'h0006, 1, T, 0, 0);
        end

        cfg(3'd6, 1'b0, 16'h0003);
        cyc("m2_load", 1, 0, 0, 0, 0, 16'h0003, 0, T, 0, 0);
        cyc("m2_dec2", 0, 1, 0, 0, 0, 16'h0002, 0, T, 0, X);
        cyc("m2_dec1", 0, 1, 0, 0, 0, 16'h0001, 0, T, 0, X);
        cyc("m2_reload", 0, 1, 0, 0, 0, 16'h0003, 1, T, 0, 0);
        cyc("m2_after", 0, 1, 0, 0, 0, 16'h0002, 0, T, 0, X);
        cyc("hold", 0, 0, 0, 0, 0, 16'h0002, 0, T, 0, X);

        cfg(3'd0, 1'b0, 16'h0100);
        cyc("ol_load", 1, 0, 0, 0, 0, 16'h0100, 0, T, 0, 0);
        for (int i = 1; i <= 5; i++) cyc("ol_count", 0, 1, 0, 0, 0, 16'h0100 - 16'(i), 0, T, 0, X);
        cyc("ol_latch", 0, 1, 0, 1, 0, 16'h00FA, 0, 16'h00FA, 1, X);
        cyc("ol_latch2", 0, 1, 0, 1, 0, 16'h00F9, 0, 16'h00FA, 1, X);
        cyc("ol_hold", 0, 1, 0, 0, 0, 16'h00F8, 0, 16'h00FA, 1, X);
        cyc("ol_release", 0, 1, 0, 0, 1, 16'h00F7, 0, T, 0, X);
        cyc("ol_track", 0, 1, 0, 0, 0, 16'h00F6, 0, T, 0, X);
        cyc("ol_relatch", 0, 1, 0, 1, 0, 16'h00F5, 0, 16'h00F5, 1, X);
        cyc("ol_rel_lat", 0, 1, 0, 1, 1, 16'h00F4, 0, 16'h00F4, 1, X);
        cyc("ol_held", 0, 1, 0, 0, 0, 16'h00F3, 0, 16'h00F4, 1, X);
        cyc("ol_rel2", 0, 1, 0, 0, 1, 16'h00F2, 0, T, 0, X);

        cyc("crw", 0, 1, 1, 0, 0, 16'h00F1, 0, T, 0, 1);
        cyc("crw_load", 1, 1, 1, 0, 0, 16'h0100, 0, T, 0, 1);
        cyc("load_en", 1, 1, 0, 0, 0, 16'h0100, 0, T, 0, 0);

        cfg(3'd0, 1'b0, 16'h0002);
        cyc("sup_load", 1, 0, 0, 0, 0, 16'h0002, 0, T, 0, 0);
        cyc("sup_dec", 0, 1, 0, 0, 0, 16'h0001, 0, T, 0, X);
        cyc("sup_ld_at1", 1, 1, 0, 0, 0, 16'h0002, 0, T, 0, 0);
        cyc("sup_dec2", 0, 1, 0, 0, 0, 16'h0001, 0, T, 0, X);
        cyc("sup_tc", 0, 0, 0, 0, 0, 16'h0001, 0, T, 0, X);

        cfg(3'd0, 1'b0, 16'h1234);
        cyc("ar_load", 1, 0, 0, 0, 0, 16'h1234, 0, T, 0, 0);
        cyc("ar_dec", 0, 1, 0, 0, 0, 16'h1233, 0, T, 0, X);
        cyc("ar_latch", 0, 1, 0, 1, 0, 16'h1232, 0, 16'h1232, 1, 0);
        @(negedge clk);
        #2;
        push("async_rst", 16'h0000, 1'b0, 0, 0, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc("post_rst", 0, 1, 0, 0, 0, 16'hFFFF, 0, T, 0, 1);

        repeat (2) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/counting_element.md
Name: counting_element

Overview:
- 16-bit down-counting element (CE) of one 8254 counter channel. Sits directly downstream of the channel control logic.
- Loads the count register value on load_new_count and decrements on clk while count_enable is high.
- Handles binary/BCD arithmetic, the mode 2/3 auto-reload and the mode 3 step of 2.
- Feeds current_count back to control logic and an output latch (OL) to the read logic.

Parameters:
WIDTH, 16, counter width; fixed at 16 for 8254 compatibility (must be a multiple of 4).
RESET_COUNT, 16'h0000, CE value after reset.

Ports:
clk  input  1  counter clock (CLK pin of the channel)
rst_n  input  1  asynchronous active-low reset
initial_count  input  16  count register (CR) contents, assembled by write logic
cr_write  input  1  CR written this cycle (either byte); sets null_count
load_new_count  input  1  transfer CR into CE on this edge
count_enable  input  1  decrement enable from control logic
mode  input  3  counter mode (control_word[3:1]); 6/7 treated as 2/3
bcd  input  1  1 = BCD counting (control_word[0])
latch_cmd  input  1  counter-latch command for this channel
ol_release  input  1  read logic has finished reading the latched value
current_count  output  16  CE value
ol_value  output  16  output latch value seen by read logic
ol_latched  output  1  OL frozen
null_count  output  1  CR written but not yet loaded into CE
tc_pulse  output  1  one-clock terminal-count pulse

Behaviour:
- Reset (async, rst_n=0): current_count=RESET_COUNT, ol_value=RESET_COUNT, ol_latched=0, null_count=1, tc_pulse=0. Deassertion takes effect at the next clk edge. Reset mid-count aborts the count with no tc_pulse.
- All state updates on posedge clk. Priority per edge: load > decrement > hold.
- Load: on load_new_count, CE <= initial_count. Mode 3 clears bit0 (odd count N loads N-1). null_count <= 0 unless cr_write is also high that cycle (then stays 1).
- cr_write without load_new_count: null_count <= 1.
- Decrement (count_enable=1, no load):
  - Step is 2 in mode 3, otherwise 1.
  - Binary: modulo 2^16, so 0x0000-1 -> 0xFFFF.
  - BCD: per-digit borrow, so 0000-1 -> 9999 and 0010-1 -> 0009. In mode 3 BCD, 0000-2 -> 9998.
  - A loaded count of 0 is therefore 65536 (binary) or 10000 (BCD).
  - Non-BCD digit values in BCD mode: result undefined, but no X propagation.
- Auto-reload:
  - Mode 2: when CE==1 and enabled, next CE = initial_count instead of 0.
  - Mode 3: when CE==2 and enabled, next CE = initial_count with bit0 cleared.
  - A reload does not affect null_count.
- tc_pulse:
  - Registered; high for exactly one clk after the edge on which CE went 1->0 (modes 0,1,4,5) or the edge on which a mode 2/3 reload occurred.
  - Wrap 0->FFFF/9999 does not pulse.
  - A load on the same edge suppresses the pulse.
- Output latch:
  - ol_latched=0: ol_value tracks the post-edge CE every cycle.
  - latch_cmd with ol_latched=0: ol_value freezes at the CE value after that edge, and ol_latched <= 1.
  - latch_cmd while ol_latched=1: ignored; the first latch holds.
  - ol_release: ol_latched <= 0, and tracking resumes the same edge.
  - latch_cmd and ol_release on the same edge: release then re-latch, so ol_value = new CE and ol_latched stays 1.
- Hold: count_enable=0 and no load means CE is unchanged.
- Mode change does not alter CE; only the next load/step uses the new mode.

Optional Feature:
- Macro BCD_COUNT_EN.
- Defined: bcd input selects BCD arithmetic as described above.
- Undefined: bcd is ignored, all arithmetic is binary, and BCD decrement logic is not synthesised.

Test Plan:
- Reset, mode 0 binary, load 0x0005, enable -> current_count 5,4,3,2,1,0,FFFF. tc_pulse high only in the cycle after 1->0.
- BCD_COUNT_EN, bcd=1, load 0x0010, enable -> 0009 after 1 clk. Load 0x0000 -> 9999 after 1 clk.
- Mode 3 binary, load 7, enable -> 6,4,2,6,4,2… with tc_pulse after each reload. Mode 2, load 3 -> 3,2,1,3 with tc_pulse after reload.
- Counting from 0x0100: latch_cmd at CE=0x00FA -> ol_value stays 0x00FA through a second latch_cmd while CE keeps counting. ol_release -> ol_value tracks CE next cycle.
- cr_write -> null_count=1. load_new_count with count_enable=1 same edge -> CE = initial_count (no decrement) and null_count=0.
- Counting from 0x1234: pull rst_n low asynchronously between edges -> current_count=0, null_count=1, ol_latched=0 immediately, no tc_pulse.
